// File: rtl/piso_tx_if.sv
// Parallel-load / serial-out handshake bundle for piso_tx.
// master = parallel data source side, slave = the transmitter.
interface piso_tx_if #(
  parameter int WIDTH = 4
);
  logic             load;
  logic [WIDTH-1:0] in;
  logic             ready;
  logic             sout;
  logic             sout_valid;
  logic             done;

  modport master (
    output load, in,
    input  ready, sout, sout_valid, done
  );

  modport slave (
    input  load, in,
    output ready, sout, sout_valid, done
  );
endinterface

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter, MSB first, one bit per clk, registered outputs.
// Optional even-parity trailer bit when PISO_PARITY_EN is defined.
module piso_tx #(
  parameter int WIDTH = 4
) (
  input logic     clk,
  input logic     rst,
  piso_tx_if.slave bus
);

`ifdef PISO_PARITY_EN
  localparam int L = WIDTH + 1;
`else
  localparam int L = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] C_LAST = CW'(L - 1);
  localparam logic [CW-1:0] C_PEN  = CW'(L - 2);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_cnt;
  logic             r_ready;
  logic             r_sout;
  logic             r_sout_valid;
  logic             r_done;
  logic             w_next_bit;

`ifdef PISO_PARITY_EN
  localparam logic [CW-1:0] C_PAR_SEL = CW'(WIDTH - 1);
  logic r_par;

  always_ff @(posedge clk) begin
    if (rst)
      r_par <= 1'b0;
    else if (r_state == IDLE && bus.load)
      r_par <= ^bus.in;
  end

  // Once the LSB has been sent, the parity bit follows instead of shifted-in zeros.
  assign w_next_bit = (r_cnt == C_PAR_SEL) ? r_par : r_shift[WIDTH-2];
`else
  assign w_next_bit = r_shift[WIDTH-2];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_shift      <= '0;
      r_cnt        <= '0;
      r_ready      <= 1'b1;
      r_sout       <= 1'b0;
      r_sout_valid <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.load) begin
            r_state      <= SHIFT;
            r_shift      <= bus.in;
            r_cnt        <= '0;
            r_ready      <= 1'b0;
            r_sout       <= bus.in[WIDTH-1];
            r_sout_valid <= 1'b1;
            r_done       <= 1'b0;
          end
        end
        SHIFT: begin
          // Counter ends the frame parked at L and holds there until the next accept.
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == C_LAST) begin
            r_state      <= IDLE;
            r_ready      <= 1'b1;
            r_sout       <= 1'b0;
            r_sout_valid <= 1'b0;
            r_done       <= 1'b0;
          end else begin
            r_shift <= {r_shift[WIDTH-2:0], 1'b0};
            r_sout  <= w_next_bit;
            r_done  <= (r_cnt == C_PEN);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.ready      = r_ready;
  assign bus.sout       = r_sout;
  assign bus.sout_valid = r_sout_valid;
  assign bus.done       = r_done;

endmodule

// File: tb/tb_piso_tx.sv
// Randomized self-checking bench for piso_tx against a queue-based frame model.
// Build with +define+PISO_PARITY_EN to cover the parity trailer.
module tb_piso_tx;
  localparam int W = 4;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_bad;

  piso_tx_if #(.WIDTH(W)) bus ();

  piso_tx #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: bits of the frame still to be shown, front = bit currently on sout.
  bit q_bits[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic ld, input logic [W-1:0] d);
    if (r) begin
      q_bits.delete();
    end else if (q_bits.size() != 0) begin
      void'(q_bits.pop_front());
    end else if (ld) begin
      for (int i = W - 1; i >= 0; i--) q_bits.push_back(d[i]);
`ifdef PISO_PARITY_EN
      q_bits.push_back(^d);
`endif
    end
  endtask

  task automatic step();
    logic          r_s;
    logic          ld_s;
    logic [W-1:0]  d_s;
    r_s  = rst;
    ld_s = bus.load;
    d_s  = bus.in;
    @(posedge clk);
    model_edge(r_s, ld_s, d_s);
    #1;
    check("ready",      32'(bus.ready),      32'(q_bits.size() == 0));
    check("sout_valid", 32'(bus.sout_valid), 32'(q_bits.size() != 0));
    check("sout",       32'(bus.sout),       32'((q_bits.size() != 0) ? q_bits[0] : 1'b0));
    check("done",       32'(bus.done),       32'(q_bits.size() == 1));
  endtask

  task automatic drive(input logic r, input logic ld, input logic [W-1:0] d, input int cycles);
    rst      = r;
    bus.load = ld;
    bus.in   = d;
    for (int i = 0; i < cycles; i++) step();
  endtask

  initial begin
    n_vec    = 0;
    n_bad    = 0;
    rst      = 1'b1;
    bus.load = 1'b0;
    bus.in   = '0;

    drive(1'b1, 1'b0, 4'h0, 2);
    drive(1'b0, 1'b0, 4'h0, 3);

    // single frame 1010
    drive(1'b0, 1'b1, 4'b1010, 1);
    drive(1'b0, 1'b0, 4'b0101, 7);

    // load while busy is ignored
    drive(1'b0, 1'b1, 4'b1100, 1);
    drive(1'b0, 1'b0, 4'b1100, 1);
    drive(1'b0, 1'b1, 4'b0011, 1);
    drive(1'b0, 1'b0, 4'b0011, 6);

    // reset on the 3rd bit aborts the frame
    drive(1'b0, 1'b1, 4'b1111, 1);
    drive(1'b0, 1'b0, 4'b1111, 1);
    drive(1'b1, 1'b0, 4'b1111, 1);
    drive(1'b0, 1'b0, 4'b1111, 4);

    // load held high, data changes after the first accept
    drive(1'b0, 1'b1, 4'b0110, 1);
    drive(1'b0, 1'b1, 4'b1001, 2 * (W + 2));
    drive(1'b0, 1'b0, 4'b0000, 4);

    // load asserted together with reset is ignored
    drive(1'b1, 1'b1, 4'b1011, 2);
    drive(1'b0, 1'b0, 4'b1011, 2);

    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 2) != 0),
            W'($urandom), 1);
    end
    drive(1'b0, 1'b0, 4'h0, 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
